shift_exec_unit: RTL

SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

---
 rtl/shift_exec_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/shift_exec_unit.sv
// ============================================================================
// shift_exec_unit: 32-bit iterative shifter (SLL/SRL/SRA/pass), one bit per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_exec_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rd_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= 32'h0000_0000;
            cnt_q   <= 5'd0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    data_d = rs1_i;
                    op_d   = op_i;
                    cnt_d  = rs2_i[4:0];
                    if ((rs2_i[4:0] == 5'd0) || (op_i == OP_PASS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL:  data_d = {data_q[30:0], 1'b0};
                    OP_SRL:  data_d = {1'b0, data_q[31:1]};
                    OP_SRA:  data_d = {data_q[31], data_q[31:1]};
                    default: data_d = data_q;
                endcase
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over any accept or handoff decided above.
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign busy_o  = (state_q != IDLE);
    assign rd_o    = data_q;

endmodule

`default_nettype wire
